// File: rtl/ip_csum_sched.sv
`default_nettype none
// ============================================================================
// Module   : ip_csum_sched
// Brief    : Two-requester round-robin front end for a shared pipelined
//            checksum core. Responses are routed back to requesters by a tag pipeline.
// Revision : 1.0
// ============================================================================
module ip_csum_sched #(
    parameter int CSUM_LAT  = 4,
    parameter int TAG_DEPTH = CSUM_LAT + 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_pkt_len,
    input  logic [31:0] req0_src_ip,
    input  logic [31:0] req0_dst_ip,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_pkt_len,
    input  logic [31:0] req1_src_ip,
    input  logic [31:0] req1_dst_ip,

    output logic [15:0] cs_pkt_len,
    output logic [31:0] cs_src_ip,
    output logic [31:0] cs_dst_ip,
    input  logic [15:0] cs_result,

    output logic        rsp0_valid,
    output logic [15:0] rsp0_csum,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_csum,

    output logic        busy
);

    localparam int CNT_W = $clog2(TAG_DEPTH + 2);

    logic                 r_last_grant;
    logic [15:0]          r_cs_pkt_len;
    logic [31:0]          r_cs_src_ip;
    logic [31:0]          r_cs_dst_ip;
    logic [TAG_DEPTH-1:0] r_tag_v;
    logic [TAG_DEPTH-1:0] r_tag_id;
    logic                 r_rsp0_valid;
    logic                 r_rsp1_valid;
    logic [15:0]          r_rsp0_csum;
    logic [15:0]          r_rsp1_csum;
    logic [CNT_W-1:0]     r_outstanding;

    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_hs;
    logic                 w_hs_id;
    logic                 w_rsp;
    logic                 w_tag_out_v;
    logic                 w_tag_out_id;

    // Grants are suppressed during reset so no handshake can slip through.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = !r_last_grant;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_hs         = w_gnt0 | w_gnt1;
    assign w_hs_id      = w_gnt1;
    assign w_rsp        = r_rsp0_valid | r_rsp1_valid;
    assign w_tag_out_v  = r_tag_v[TAG_DEPTH-1];
    assign w_tag_out_id = r_tag_id[TAG_DEPTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant  <= 1'b1;
            r_cs_pkt_len  <= '0;
            r_cs_src_ip   <= '0;
            r_cs_dst_ip   <= '0;
            r_tag_v       <= '0;
            r_tag_id      <= '0;
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_csum   <= '0;
            r_rsp1_csum   <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_hs) begin
                r_last_grant <= w_hs_id;
                r_cs_pkt_len <= w_gnt1 ? req1_pkt_len : req0_pkt_len;
                r_cs_src_ip  <= w_gnt1 ? req1_src_ip  : req0_src_ip;
                r_cs_dst_ip  <= w_gnt1 ? req1_dst_ip  : req0_dst_ip;
            end

            r_tag_v  <= {r_tag_v[TAG_DEPTH-2:0],  w_hs};
            r_tag_id <= {r_tag_id[TAG_DEPTH-2:0], w_hs_id};

            // The exiting tag lines up with the core result for that handshake.
            r_rsp0_valid <= w_tag_out_v && !w_tag_out_id;
            r_rsp1_valid <= w_tag_out_v &&  w_tag_out_id;
            if (w_tag_out_v && !w_tag_out_id) begin
                r_rsp0_csum <= cs_result;
            end
            if (w_tag_out_v && w_tag_out_id) begin
                r_rsp1_csum <= cs_result;
            end

            case ({w_hs, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign cs_pkt_len = r_cs_pkt_len;
    assign cs_src_ip  = r_cs_src_ip;
    assign cs_dst_ip  = r_cs_dst_ip;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_csum  = r_rsp0_csum;
    assign rsp1_csum  = r_rsp1_csum;
    assign busy       = (r_outstanding != '0);

endmodule
`default_nettype wire

// File: tb/tb_ip_csum_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_csum_sched
// Brief    : Directed self-checking bench for ip_csum_sched with a 4-cycle
//            pseudo-header checksum core model.
// Revision : 1.0
// ============================================================================
module tb_ip_csum_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [15:0] req0_pkt_len = '0;
    logic [31:0] req0_src_ip = '0;
    logic [31:0] req0_dst_ip = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [15:0] req1_pkt_len = '0;
    logic [31:0] req1_src_ip = '0;
    logic [31:0] req1_dst_ip = '0;
    logic [15:0] cs_pkt_len;
    logic [31:0] cs_src_ip;
    logic [31:0] cs_dst_ip;
    logic [15:0] cs_result;
    logic        rsp0_valid;
    logic [15:0] rsp0_csum;
    logic        rsp1_valid;
    logic [15:0] rsp1_csum;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    ip_csum_sched #(.CSUM_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pkt_len(req0_pkt_len),
        .req0_src_ip(req0_src_ip), .req0_dst_ip(req0_dst_ip),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pkt_len(req1_pkt_len),
        .req1_src_ip(req1_src_ip), .req1_dst_ip(req1_dst_ip),
        .cs_pkt_len(cs_pkt_len), .cs_src_ip(cs_src_ip), .cs_dst_ip(cs_dst_ip),
        .cs_result(cs_result),
        .rsp0_valid(rsp0_valid), .rsp0_csum(rsp0_csum),
        .rsp1_valid(rsp1_valid), .rsp1_csum(rsp1_csum),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Ones-complement pseudo-header checksum (src, dst, proto 6, length).
    function automatic logic [15:0] model_csum(input logic [15:0] len,
                                               input logic [31:0] s,
                                               input logic [31:0] d);
        logic [31:0] sum;
        sum = 32'(s[31:16]) + 32'(s[15:0]) + 32'(d[31:16]) + 32'(d[15:0])
            + 32'h0006 + 32'(len);
        sum = 32'(sum[15:0]) + 32'(sum[31:16]);
        sum = 32'(sum[15:0]) + 32'(sum[31:16]);
        return ~sum[15:0];
    endfunction

    // Core samples cs_* at an edge; result appears 4 edges later.
    logic [15:0] core_pipe [0:3] = '{default: 16'h0};
    always @(posedge clk) begin
        core_pipe[0] <= model_csum(cs_pkt_len, cs_src_ip, cs_dst_ip);
        core_pipe[1] <= core_pipe[0];
        core_pipe[2] <= core_pipe[1];
        core_pipe[3] <= core_pipe[2];
    end
    assign cs_result = core_pipe[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_errors++; $display("FAIL reset_ready got %b expected 00", {req0_ready, req1_ready});
        end
        n_checks++;
        if ({cs_pkt_len, cs_src_ip, cs_dst_ip} !== 80'h0) begin
            n_errors++; $display("FAIL reset_cs got %h expected 0", {cs_pkt_len, cs_src_ip, cs_dst_ip});
        end
        n_checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_csum, rsp1_csum, busy} !== 35'h0) begin
            n_errors++; $display("FAIL reset_rsp got %h expected 0",
                                 {rsp0_valid, rsp1_valid, rsp0_csum, rsp1_csum, busy});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        tick();
        req0_valid   = 1'b1;
        req0_pkt_len = 16'h003C;
        req0_src_ip  = 32'hC0A80001;
        req0_dst_ip  = 32'hC0A800C7;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_errors++; $display("FAIL single_grant got %b expected 10", {req0_ready, req1_ready});
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            req0_valid = 1'b0;
            #1;
            if (k == 1) begin
                n_checks++;
                if ({cs_pkt_len, cs_src_ip, cs_dst_ip} !== {16'h003C, 32'hC0A80001, 32'hC0A800C7}) begin
                    n_errors++; $display("FAIL single_cs got %h %h %h", cs_pkt_len, cs_src_ip, cs_dst_ip);
                end
            end
            n_checks++;
            if ({rsp0_valid, rsp1_valid} !== {(k == 6), 1'b0}) begin
                n_errors++; $display("FAIL single_rsp_valid t+%0d got %b expected %b",
                                     k, {rsp0_valid, rsp1_valid}, {(k == 6), 1'b0});
            end
            n_checks++;
            if (busy !== (k <= 6)) begin
                n_errors++; $display("FAIL single_busy t+%0d got %b expected %b", k, busy, (k <= 6));
            end
            if (k == 6) begin
                n_checks++;
                if (rsp0_csum !== 16'h7DA4) begin
                    n_errors++; $display("FAIL single_csum got %h expected 7da4", rsp0_csum);
                end
            end
        end
    endtask

    task automatic test_idle_hold();
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if ({cs_pkt_len, cs_src_ip, cs_dst_ip} !== {16'h003C, 32'hC0A80001, 32'hC0A800C7}) begin
                n_errors++; $display("FAIL idle_cs cyc %0d got %h %h %h", k, cs_pkt_len, cs_src_ip, cs_dst_ip);
            end
            n_checks++;
            if ({rsp0_valid, rsp1_valid, busy, rsp0_csum, rsp1_csum} !== {3'b000, 16'h7DA4, 16'h0000}) begin
                n_errors++; $display("FAIL idle_rsp cyc %0d got v=%b busy=%b c0=%h c1=%h expected 00 0 7da4 0000",
                                     k, {rsp0_valid, rsp1_valid}, busy, rsp0_csum, rsp1_csum);
            end
        end
    endtask

    task automatic test_contention();
        logic [15:0] len_j;
        logic        exp0;
        logic        exp1;
        int          j;
        do_reset();
        req0_src_ip = 32'h0A000001; req0_dst_ip = 32'h0A000002;
        req1_src_ip = 32'hAC100005; req1_dst_ip = 32'hAC1000FE;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            if (k < 6) begin
                req0_valid = 1'b1; req1_valid = 1'b1;
                req0_pkt_len = 16'h0100 + 16'(k);
                req1_pkt_len = 16'h0200 + 16'(k);
            end else begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            #1;
            if (k < 6) begin
                n_checks++;
                if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_errors++; $display("FAIL contention_grant cyc %0d got %b", k, {req0_ready, req1_ready});
                end
            end
            j = k - 6;
            exp0 = (j >= 0) && (j < 6) && (j % 2 == 0);
            exp1 = (j >= 0) && (j < 6) && (j % 2 == 1);
            n_checks++;
            if ({rsp0_valid, rsp1_valid} !== {exp0, exp1}) begin
                n_errors++; $display("FAIL contention_rsp cyc %0d got %b expected %b",
                                     k, {rsp0_valid, rsp1_valid}, {exp0, exp1});
            end
            if (exp0) begin
                len_j = 16'h0100 + 16'(j);
                n_checks++;
                if (rsp0_csum !== model_csum(len_j, 32'h0A000001, 32'h0A000002)) begin
                    n_errors++; $display("FAIL contention_csum0 j=%0d got %h expected %h",
                                         j, rsp0_csum, model_csum(len_j, 32'h0A000001, 32'h0A000002));
                end
            end
            if (exp1) begin
                len_j = 16'h0200 + 16'(j);
                n_checks++;
                if (rsp1_csum !== model_csum(len_j, 32'hAC100005, 32'hAC1000FE)) begin
                    n_errors++; $display("FAIL contention_csum1 j=%0d got %h expected %h",
                                         j, rsp1_csum, model_csum(len_j, 32'hAC100005, 32'hAC1000FE));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] len_j;
        logic        exp1;
        tick();
        req1_src_ip = 32'h01020304; req1_dst_ip = 32'h05060708;
        for (int k = 0; k <= 15; k++) begin
            if (k > 0) tick();
            if (k < 8) begin
                req1_valid = 1'b1;
                req1_pkt_len = 16'(k + 1);
            end else begin
                req1_valid = 1'b0;
            end
            #1;
            if (k < 8) begin
                n_checks++;
                if ({req0_ready, req1_ready} !== 2'b01) begin
                    n_errors++; $display("FAIL b2b_grant cyc %0d got %b expected 01", k, {req0_ready, req1_ready});
                end
            end
            n_checks++;
            if (busy !== ((k >= 1) && (k <= 13))) begin
                n_errors++; $display("FAIL b2b_busy t+%0d got %b expected %b", k, busy, ((k >= 1) && (k <= 13)));
            end
            exp1 = (k >= 6) && (k <= 13);
            n_checks++;
            if ({rsp0_valid, rsp1_valid} !== {1'b0, exp1}) begin
                n_errors++; $display("FAIL b2b_rsp t+%0d got %b expected %b", k, {rsp0_valid, rsp1_valid}, {1'b0, exp1});
            end
            if (exp1) begin
                len_j = 16'(k - 5);
                n_checks++;
                if (rsp1_csum !== model_csum(len_j, 32'h01020304, 32'h05060708)) begin
                    n_errors++; $display("FAIL b2b_csum t+%0d got %h expected %h",
                                         k, rsp1_csum, model_csum(len_j, 32'h01020304, 32'h05060708));
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        tick();
        req0_src_ip = 32'h11111111; req0_dst_ip = 32'h22222222;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) tick();
            if (k < 3) begin
                req0_valid = 1'b1; req0_pkt_len = 16'h0010 + 16'(k);
            end else if (k == 3) begin
                rst_n = 1'b0; req0_valid = 1'b1;
            end else begin
                rst_n = 1'b1; req0_valid = 1'b0;
            end
            #1;
            if (k == 3) begin
                n_checks++;
                if ({req0_ready, req1_ready} !== 2'b00) begin
                    n_errors++; $display("FAIL midreset_ready got %b expected 00", {req0_ready, req1_ready});
                end
            end
            if (k >= 1 && k <= 3) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_errors++; $display("FAIL midreset_busy_pre t+%0d got %b expected 1", k, busy);
                end
            end
            if (k >= 4) begin
                n_checks++;
                if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
                    n_errors++; $display("FAIL midreset_after t+%0d got v=%b busy=%b expected 00 0",
                                         k, {rsp0_valid, rsp1_valid}, busy);
                end
            end
        end
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_errors++; $display("FAIL midreset_grant got %b expected 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_idle_hold();
        test_contention();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
